pipe_ctrl: RTL

Central sequencing controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
- Consumes decode-level control (memtoreg, regwrite, SYSTEM/halt indication) plus EX/MEM status.
- Generates per-stage stall/flush, freezes the pipeline during multi-cycle data-memory accesses, and runs the halt-drain sequence that retires in-flight instructions before asserting halted.

---
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Control/status bundle between the 5-stage core datapath and its sequencing controller.
// The master side is the datapath, which supplies hazard info and receives stall/flush/halt.
interface pipe_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_hlt;
  logic [4:0] ex_rd;
  logic       ex_regwrite;
  logic       ex_memtoreg;
  logic       ex_take;
  logic       mem_req;
  logic       mem_ack;
  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       flush_id;
  logic       flush_ex;
  logic       halted;
  logic       mem_err;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_hlt,
    output ex_rd, ex_regwrite, ex_memtoreg, ex_take, mem_req, mem_ack,
    input  stall_if, stall_id, stall_ex, flush_id, flush_ex, halted, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_hlt,
    input  ex_rd, ex_regwrite, ex_memtoreg, ex_take, mem_req, mem_ack,
    output stall_if, stall_id, stall_ex, flush_id, flush_ex, halted, mem_err
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: hazard stalls/flushes, memory-wait freeze with timeout,
// and the halt-drain sequence that retires in-flight instructions before halting.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] drain_cnt_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;
  logic             halted_reg;
  logic             mem_err_reg;

  logic freeze;
  logic load_use;
  logic hlt_accept;

  assign freeze = bus.mem_req & ~bus.mem_ack & ~mem_err_reg;

  // A load targeting x0 never produces a value, so it cannot create a hazard.
  assign load_use = bus.ex_memtoreg & bus.ex_regwrite & (bus.ex_rd != 5'd0) &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  assign hlt_accept = (state_reg == RUN) & ~freeze & ~bus.ex_take & ~load_use & bus.id_hlt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      halted_reg    <= 1'b0;
      mem_err_reg   <= 1'b0;
    end else begin
      if (freeze) begin
        if (tmo_cnt_reg != TMO_MAX)
          tmo_cnt_reg <= tmo_cnt_reg + CNT_ONE;
      end else begin
        tmo_cnt_reg <= '0;
      end

      // The timeout edge is the one on which the counter reaches MEM_TIMEOUT.
      if (freeze && (tmo_cnt_reg >= TMO_LAST)) begin
        mem_err_reg <= 1'b1;
        state_reg   <= HALTED;
        halted_reg  <= 1'b1;
      end else begin
        case (state_reg)
          RUN: begin
            if (hlt_accept) begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= DRAIN_INIT;
            end
          end
          DRAIN: begin
            if (!freeze) begin
              if (drain_cnt_reg <= CNT_ONE) begin
                state_reg     <= HALTED;
                halted_reg    <= 1'b1;
                drain_cnt_reg <= '0;
              end else begin
                drain_cnt_reg <= drain_cnt_reg - CNT_ONE;
              end
            end
          end
          HALTED:  halted_reg <= 1'b1;
          default: state_reg  <= RUN;
        endcase
      end
    end
  end

  always_comb begin
    bus.stall_if = 1'b0;
    bus.stall_id = 1'b0;
    bus.stall_ex = 1'b0;
    bus.flush_id = 1'b0;
    bus.flush_ex = 1'b0;
    if (!rst_n) begin
      bus.stall_if = 1'b0;
    end else if ((state_reg == HALTED) || freeze) begin
      bus.stall_if = 1'b1;
      bus.stall_id = 1'b1;
      bus.stall_ex = 1'b1;
    end else if (state_reg == DRAIN) begin
      bus.stall_if = 1'b1;
      bus.flush_id = 1'b1;
      bus.flush_ex = 1'b1;
    end else if (bus.ex_take) begin
      bus.flush_id = 1'b1;
      bus.flush_ex = 1'b1;
    end else if (load_use) begin
      bus.stall_if = 1'b1;
      bus.stall_id = 1'b1;
      bus.flush_ex = 1'b1;
    end else if (bus.id_hlt) begin
      bus.stall_if = 1'b1;
      bus.flush_id = 1'b1;
    end
  end

  assign bus.halted  = halted_reg;
  assign bus.mem_err = mem_err_reg;

endmodule
